// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the opcode control decoder.
// Owns the PC and keeps at most one instruction-memory request outstanding.
// A fetched word is held for decode until it is consumed. A branch redirect
// takes priority over everything else; a response that was already in
// flight when the redirect arrived is dropped.
// Optional build macro FETCH_PERF_CNT_EN adds the fetch/stall counters.
module fetch_unit #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [10:0]       opcode,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count
`endif
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_DELIVER = 2'd2
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] instr_pc_reg;
  logic [31:0]       instr_reg;
  logic              discard_reg;
  logic              req_valid_reg;
  logic              instr_valid_reg;

  logic [ADDR_W-1:0] redirect_target;
  logic              req_fire;

  // Branch targets are word aligned; the low two bits are simply cleared.
  assign redirect_target = redirect_pc & ~ADDR_W'(3);
  assign req_fire        = req_valid_reg & imem_req_ready;

  assign imem_req_valid = req_valid_reg;
  assign imem_addr      = pc_reg;
  assign instr_valid    = instr_valid_reg;
  assign instr          = instr_reg;
  assign instr_pc       = instr_pc_reg;
  assign opcode         = instr_reg[31:21];

  // Fetch FSM: all outputs are registered. The request valid stays low in the
  // first cycle after reset release, so the first request issues one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_REQ;
      pc_reg          <= RESET_PC;
      instr_pc_reg    <= '0;
      instr_reg       <= '0;
      discard_reg     <= 1'b0;
      req_valid_reg   <= 1'b0;
      instr_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_REQ: begin
          if (req_fire) begin
            // Request accepted; if redirected in the same cycle its data is stale.
            state_reg     <= S_WAIT;
            req_valid_reg <= 1'b0;
            if (redirect_valid) begin
              discard_reg <= 1'b1;
            end
          end else begin
            req_valid_reg <= 1'b1;
          end
          if (redirect_valid) begin
            pc_reg <= redirect_target;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (discard_reg || redirect_valid) begin
              discard_reg   <= 1'b0;
              state_reg     <= S_REQ;
              req_valid_reg <= 1'b1;
            end else begin
              instr_reg       <= imem_resp_data;
              instr_pc_reg    <= pc_reg;
              instr_valid_reg <= 1'b1;
              state_reg       <= S_DELIVER;
            end
          end else if (redirect_valid) begin
            // Still one response owed by memory; mark it to be dropped.
            discard_reg <= 1'b1;
          end
          if (redirect_valid) begin
            pc_reg <= redirect_target;
          end
        end
        S_DELIVER: begin
          if (redirect_valid) begin
            pc_reg          <= redirect_target;
            instr_valid_reg <= 1'b0;
            req_valid_reg   <= 1'b1;
            state_reg       <= S_REQ;
          end else if (instr_ready) begin
            pc_reg          <= pc_reg + ADDR_W'(4);
            instr_valid_reg <= 1'b0;
            req_valid_reg   <= 1'b1;
            state_reg       <= S_REQ;
          end
        end
        default: begin
          state_reg       <= S_REQ;
          req_valid_reg   <= 1'b0;
          instr_valid_reg <= 1'b0;
          discard_reg     <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic fetch_event;
  logic stall_event;

  assign fetch_event = instr_valid_reg & instr_ready;
  assign stall_event = ((state_reg == S_REQ)  & ~imem_req_ready) |
                       ((state_reg == S_WAIT) & ~imem_resp_valid);

  // Saturating performance counters for delivered instructions and stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (fetch_event && (fetch_count != 32'hFFFF_FFFF)) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (stall_event && (stall_count != 32'hFFFF_FFFF)) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule
